// File: rtl/fifo_width_down_pkg.sv
`default_nettype none
// ============================================================================
// Module   : fifo_width_down_pkg
// Brief    : Shared state encoding for the narrowing width converter.
// Revision : 1.0
// ============================================================================
package fifo_width_down_pkg;

    typedef logic [0:0] state_t;

    localparam state_t c_st_idle = 1'b0;
    localparam state_t c_st_busy = 1'b1;

endpackage
`default_nettype wire

// File: rtl/fifo_width_down_ffs.sv
`default_nettype none
// ============================================================================
// Module   : fifo_width_down_ffs
// Brief    : Find-first-set on a mask: lowest set index, one-hot and empty flags.
// Revision : 1.0
// ============================================================================
module fifo_width_down_ffs #(
    parameter int WIDTH = 4
) (
    input  logic [WIDTH-1:0]         mask,
    output logic [$clog2(WIDTH)-1:0] idx,
    output logic                     onehot,
    output logic                     none
);

    localparam int c_idx_width = $clog2(WIDTH);

    // Scan from the top so the lowest set bit is the one that sticks.
    always_comb begin
        idx = '0;
        for (int k = WIDTH - 1; k >= 0; k--) begin
            if (mask[k]) begin
                idx = c_idx_width'(k);
            end
        end
    end

    assign none   = (mask == '0);
    assign onehot = !none && ((mask & (mask - WIDTH'(1))) == '0);

endmodule
`default_nettype wire

// File: rtl/fifo_width_down.sv
`default_nettype none
// ============================================================================
// Module   : fifo_width_down
// Brief    : Splits IN_WIDTH words into strobe-qualified OUT_WIDTH beats, LSB first.
// Revision : 1.0
// ============================================================================
module fifo_width_down
    import fifo_width_down_pkg::*;
#(
    parameter  int IN_WIDTH  = 32,
    parameter  int OUT_WIDTH = 8,
    localparam int RATIO     = IN_WIDTH / OUT_WIDTH
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic [IN_WIDTH-1:0]  data_i,
    input  logic [RATIO-1:0]     strb_i,
    input  logic                 valid_i,
    output logic                 ready_o,
    output logic [OUT_WIDTH-1:0] data_o,
    output logic                 last_o,
    output logic                 valid_o,
    input  logic                 ready_i
);

    localparam int c_idx_width = $clog2(RATIO);

    generate
        if (((IN_WIDTH % OUT_WIDTH) != 0) || (RATIO < 2)) begin : g_bad_params
            $error("fifo_width_down: IN_WIDTH must be a multiple of OUT_WIDTH with at least 2 beats");
        end
    endgenerate

    state_t                 r_state;
    state_t                 w_state_nxt;
    logic [IN_WIDTH-1:0]    r_word;
    logic [RATIO-1:0]       r_pend;
    logic [RATIO-1:0]       w_pend_nxt;
    logic                   w_word_load;
    logic [c_idx_width-1:0] w_idx;
    logic                   w_onehot;
    logic                   w_none;
    logic [OUT_WIDTH-1:0]   w_beat;
    logic                   w_out_hs;
    logic                   w_in_hs;
    logic                   w_strb_any;

    fifo_width_down_ffs #(
        .WIDTH (RATIO)
    ) u_ffs (
        .mask   (r_pend),
        .idx    (w_idx),
        .onehot (w_onehot),
        .none   (w_none)
    );

    always_comb begin
        w_beat = '0;
        for (int k = 0; k < RATIO; k++) begin
            if (w_idx == c_idx_width'(k)) begin
                w_beat = r_word[k*OUT_WIDTH +: OUT_WIDTH];
            end
        end
    end

    // The pending mask is never empty while busy; the gate only keeps valid_o honest.
    assign valid_o    = (r_state == c_st_busy) && !w_none;
    assign last_o     = w_onehot;
    assign data_o     = w_beat;
    assign ready_o    = (r_state == c_st_idle) || (valid_o && ready_i && last_o);
    assign w_out_hs   = valid_o && ready_i;
    assign w_in_hs    = valid_i && ready_o;
    assign w_strb_any = |strb_i;

    always_comb begin
        w_state_nxt = r_state;
        w_pend_nxt  = r_pend;
        w_word_load = 1'b0;
        case (r_state)
            c_st_idle: begin
                if (w_in_hs && w_strb_any) begin
                    w_word_load = 1'b1;
                    w_pend_nxt  = strb_i;
                    w_state_nxt = c_st_busy;
                end
            end
            c_st_busy: begin
                if (w_out_hs) begin
                    if (!last_o) begin
                        w_pend_nxt = r_pend & ~(RATIO'(1) << w_idx);
                    end else if (w_in_hs && w_strb_any) begin
                        w_word_load = 1'b1;
                        w_pend_nxt  = strb_i;
                    end else begin
                        // Either no follow-on word or a zero-strobe one that is dropped.
                        w_pend_nxt  = '0;
                        w_state_nxt = c_st_idle;
                    end
                end
            end
            default: begin
                w_pend_nxt  = '0;
                w_state_nxt = c_st_idle;
            end
        endcase
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_state <= c_st_idle;
            r_pend  <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_pend  <= w_pend_nxt;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_word <= '0;
        end else if (w_word_load) begin
            r_word <= data_i;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_fifo_width_down.sv
`default_nettype none
// ============================================================================
// Module   : tb_fifo_width_down
// Brief    : Self-checking bench for fifo_width_down (directed plus random traffic).
// Revision : 1.0
// ============================================================================
module tb_fifo_width_down;

    localparam int IN_W  = 32;
    localparam int OUT_W = 8;
    localparam int RAT   = IN_W / OUT_W;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic [IN_W-1:0]  data_i = '0;
    logic [RAT-1:0]   strb_i = '0;
    logic             valid_i = 1'b0;
    logic             ready_o;
    logic [OUT_W-1:0] data_o;
    logic             last_o;
    logic             valid_o;
    logic             ready_i = 1'b0;

    fifo_width_down #(
        .IN_WIDTH  (IN_W),
        .OUT_WIDTH (OUT_W)
    ) dut (
        .clk_i   (clk),
        .rst_i   (rst),
        .data_i  (data_i),
        .strb_i  (strb_i),
        .valid_i (valid_i),
        .ready_o (ready_o),
        .data_o  (data_o),
        .last_o  (last_o),
        .valid_o (valid_o),
        .ready_i (ready_i)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct { logic [7:0] d; logic l; logic r; int c; } obs_t;
    typedef struct { logic [7:0] d; logic l; } exp_t;

    obs_t        obs_q[$];
    exp_t        exp_q[$];
    int          n_cmp = 0;
    int          n_err = 0;
    int          exp_last_cnt = 0;
    int          acc_cyc = 0;
    logic [31:0] wd [64];
    logic [3:0]  ws [64];

    // Output handshakes are recorded mid-cycle, when all inputs are stable.
    always @(negedge clk) begin : mon
        obs_t o;
        if (!rst && valid_o && ready_i) begin
            o.d = data_o;
            o.l = last_o;
            o.r = ready_o;
            o.c = cyc;
            obs_q.push_back(o);
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Reference: every strobed byte in ascending order, last on the highest strobe.
    task automatic model_word(input logic [31:0] d, input logic [3:0] s);
        exp_t e;
        for (int k = 0; k < RAT; k++) begin
            if (s[k]) begin
                e.d = d[k*8 +: 8];
                e.l = ((s >> (k + 1)) == 4'd0);
                exp_q.push_back(e);
            end
        end
        if (s != 4'd0) exp_last_cnt++;
    endtask

    task automatic run_words(input int n, input int vp, input int rp, input int max_cyc);
        int ptr  = 0;
        int c    = 0;
        bit hold = 0;
        bit done = 0;
        while (!done && c < max_cyc) begin
            tick();
            c++;
            if (ptr < n && (hold || $urandom_range(99) < vp)) begin
                valid_i = 1'b1;
                data_i  = wd[ptr];
                strb_i  = ws[ptr];
                hold    = 1'b1;
            end else begin
                valid_i = 1'b0;
                data_i  = $urandom;
                strb_i  = 4'($urandom);
            end
            ready_i = ($urandom_range(99) < rp);
            #1;
            if (ptr == n && !valid_o) begin
                done = 1'b1;
            end else if (valid_i && ready_o) begin
                model_word(wd[ptr], ws[ptr]);
                acc_cyc = cyc;
                ptr++;
                hold = 1'b0;
            end
        end
        valid_i = 1'b0;
        if (!done) begin
            n_cmp++;
            n_err++;
            $display("FAIL run_words_timeout: accepted %0d of %0d words, valid_o=%0b", ptr, n, valid_o);
        end
    endtask

    task automatic test_reset();
        #2;
        n_cmp++; if (valid_o !== 1'b0) begin n_err++; $display("FAIL reset_valid: got %0b want 0", valid_o); end
        n_cmp++; if (last_o !== 1'b0) begin n_err++; $display("FAIL reset_last: got %0b want 0", last_o); end
        n_cmp++; if (data_o !== 8'h00) begin n_err++; $display("FAIL reset_data: got %02h want 00", data_o); end
        n_cmp++; if (ready_o !== 1'b1) begin n_err++; $display("FAIL reset_ready: got %0b want 1", ready_o); end
        @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    task automatic test_full_word();
        logic [31:0] w = 32'hDDCC_BBAA;
        obs_q.delete(); exp_q.delete();
        wd[0] = w; ws[0] = 4'hF;
        run_words(1, 100, 100, 50);
        n_cmp++;
        if (obs_q.size() != 4) begin
            n_err++; $display("FAIL full_count: got %0d want 4", obs_q.size());
        end else begin
            for (int i = 0; i < 4; i++) begin
                n_cmp++;
                if (obs_q[i].d !== w[i*8 +: 8] || obs_q[i].l !== (i == 3) || obs_q[i].r !== (i == 3)) begin
                    n_err++;
                    $display("FAIL full_beat%0d: got d=%02h l=%0b r=%0b want d=%02h l=%0b r=%0b",
                             i, obs_q[i].d, obs_q[i].l, obs_q[i].r, w[i*8 +: 8], (i == 3), (i == 3));
                end
                n_cmp++;
                if (obs_q[i].c != acc_cyc + 1 + i) begin
                    n_err++; $display("FAIL full_timing%0d: got cycle %0d want %0d", i, obs_q[i].c, acc_cyc + 1 + i);
                end
            end
        end
    endtask

    task automatic test_back_to_back();
        obs_q.delete(); exp_q.delete();
        wd[0] = 32'h0403_0201; ws[0] = 4'hF;
        wd[1] = 32'h0807_0605; ws[1] = 4'hF;
        run_words(2, 100, 100, 50);
        n_cmp++;
        if (obs_q.size() != 8) begin
            n_err++; $display("FAIL b2b_count: got %0d want 8", obs_q.size());
        end else begin
            for (int i = 0; i < 8; i++) begin
                n_cmp++;
                if (obs_q[i].d !== 8'(i + 1) || obs_q[i].l !== (i == 3 || i == 7)) begin
                    n_err++;
                    $display("FAIL b2b_beat%0d: got d=%02h l=%0b want d=%02h l=%0b",
                             i, obs_q[i].d, obs_q[i].l, 8'(i + 1), (i == 3 || i == 7));
                end
                n_cmp++;
                if (obs_q[i].c != obs_q[0].c + i) begin
                    n_err++; $display("FAIL b2b_gap%0d: got cycle %0d want %0d", i, obs_q[i].c, obs_q[0].c + i);
                end
            end
            n_cmp++;
            if (obs_q[4].c != acc_cyc + 1) begin
                n_err++; $display("FAIL b2b_reload: second word first beat at %0d want %0d", obs_q[4].c, acc_cyc + 1);
            end
        end
    endtask

    task automatic test_sparse();
        logic [7:0] ed [3];
        logic       el [3];
        ed[0] = 8'h22; el[0] = 1'b0;
        ed[1] = 8'h44; el[1] = 1'b1;
        ed[2] = 8'h55; el[2] = 1'b1;
        obs_q.delete(); exp_q.delete();
        wd[0] = 32'h4433_2211; ws[0] = 4'b1010;
        wd[1] = 32'h0000_0000; ws[1] = 4'b0000;
        wd[2] = 32'h8877_6655; ws[2] = 4'b0001;
        run_words(3, 100, 100, 60);
        n_cmp++;
        if (obs_q.size() != 3) begin
            n_err++; $display("FAIL sparse_count: got %0d want 3", obs_q.size());
        end else begin
            for (int i = 0; i < 3; i++) begin
                n_cmp++;
                if (obs_q[i].d !== ed[i] || obs_q[i].l !== el[i]) begin
                    n_err++;
                    $display("FAIL sparse_beat%0d: got d=%02h l=%0b want d=%02h l=%0b",
                             i, obs_q[i].d, obs_q[i].l, ed[i], el[i]);
                end
            end
        end
    endtask

    task automatic test_backpressure();
        logic [31:0] w = 32'hDDCC_BBAA;
        int          nb = 0;
        bit          pstall = 0;
        logic [7:0]  pd = '0;
        logic        pl = 1'b0;
        obs_q.delete();
        tick();
        valid_i = 1'b1; data_i = w; strb_i = 4'hF; ready_i = 1'b0;
        for (int c = 0; c < 40 && nb != 4; c++) begin
            tick();
            valid_i = 1'b0;
            ready_i = (c % 3 == 0);
            #1;
            n_cmp++; if (valid_o !== 1'b1) begin n_err++; $display("FAIL bp_valid c%0d: got %0b want 1", c, valid_o); end
            if (pstall) begin
                n_cmp++;
                if (data_o !== pd || last_o !== pl) begin
                    n_err++; $display("FAIL bp_stable c%0d: got d=%02h l=%0b want d=%02h l=%0b", c, data_o, last_o, pd, pl);
                end
            end
            n_cmp++;
            if (ready_o !== (ready_i && nb == 3)) begin
                n_err++; $display("FAIL bp_ready c%0d: got %0b want %0b", c, ready_o, (ready_i && nb == 3));
            end
            pstall = valid_o && !ready_i;
            pd = data_o;
            pl = last_o;
            if (valid_o && ready_i) nb++;
        end
        tick();
        n_cmp++; if (valid_o !== 1'b0) begin n_err++; $display("FAIL bp_drain: valid_o got %0b want 0", valid_o); end
        n_cmp++;
        if (obs_q.size() != 4) begin
            n_err++; $display("FAIL bp_count: got %0d want 4", obs_q.size());
        end else begin
            for (int i = 0; i < 4; i++) begin
                n_cmp++;
                if (obs_q[i].d !== w[i*8 +: 8] || obs_q[i].l !== (i == 3)) begin
                    n_err++; $display("FAIL bp_order%0d: got d=%02h l=%0b want d=%02h l=%0b",
                                      i, obs_q[i].d, obs_q[i].l, w[i*8 +: 8], (i == 3));
                end
            end
        end
    endtask

    task automatic test_reset_mid_word();
        obs_q.delete(); exp_q.delete();
        tick();
        valid_i = 1'b1; data_i = 32'hDDCC_BBAA; strb_i = 4'hF; ready_i = 1'b1;
        tick();
        valid_i = 1'b0;
        tick();
        tick();
        rst = 1'b1;
        #1;
        n_cmp++; if (valid_o !== 1'b0) begin n_err++; $display("FAIL rstmid_valid: got %0b want 0", valid_o); end
        n_cmp++; if (ready_o !== 1'b1) begin n_err++; $display("FAIL rstmid_ready: got %0b want 1", ready_o); end
        n_cmp++; if (last_o !== 1'b0 || data_o !== 8'h00) begin
            n_err++; $display("FAIL rstmid_out: got d=%02h l=%0b want d=00 l=0", data_o, last_o);
        end
        n_cmp++;
        if (obs_q.size() != 2 || obs_q[0].d !== 8'hAA || obs_q[1].d !== 8'hBB) begin
            n_err++; $display("FAIL rstmid_pre: got %0d beats want AA,BB", obs_q.size());
        end
        tick();
        tick();
        rst = 1'b0;
        obs_q.delete(); exp_q.delete();
        wd[0] = 32'h0000_0001; ws[0] = 4'b0001;
        run_words(1, 100, 100, 20);
        n_cmp++;
        if (obs_q.size() != 1 || obs_q[0].d !== 8'h01 || obs_q[0].l !== 1'b1) begin
            n_err++; $display("FAIL rstmid_after: got %0d beats, first d=%02h l=%0b want 1 beat d=01 l=1",
                              obs_q.size(), (obs_q.size() > 0) ? obs_q[0].d : 8'h00,
                              (obs_q.size() > 0) ? obs_q[0].l : 1'b0);
        end
    endtask

    task automatic test_random();
        int n_last = 0;
        obs_q.delete(); exp_q.delete();
        exp_last_cnt = 0;
        for (int i = 0; i < 40; i++) begin
            wd[i] = $urandom;
            ws[i] = ($urandom_range(9) == 0) ? 4'h0 : 4'($urandom_range(15));
        end
        run_words(40, 70, 60, 4000);
        n_cmp++;
        if (obs_q.size() != exp_q.size()) begin
            n_err++; $display("FAIL rand_count: got %0d want %0d", obs_q.size(), exp_q.size());
        end else begin
            for (int i = 0; i < exp_q.size(); i++) begin
                n_cmp++;
                if (obs_q[i].d !== exp_q[i].d || obs_q[i].l !== exp_q[i].l) begin
                    n_err++; $display("FAIL rand_beat%0d: got d=%02h l=%0b want d=%02h l=%0b",
                                      i, obs_q[i].d, obs_q[i].l, exp_q[i].d, exp_q[i].l);
                end
            end
        end
        foreach (obs_q[i]) if (obs_q[i].l) n_last++;
        n_cmp++;
        if (n_last != exp_last_cnt) begin
            n_err++; $display("FAIL rand_lasts: got %0d want %0d", n_last, exp_last_cnt);
        end
    endtask

    initial begin
        test_reset();
        test_full_word();
        test_back_to_back();
        test_sparse();
        test_backpressure();
        test_reset_mid_word();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
`default_nettype wire
